sdcard_cmd_responder: RTL
=========================

Name: sdcard_cmd_responder

Overview:
- Card-side endpoint of the SD/eMMC CMD line, for use in a card model and in loopback tests of the host controller and its front end.
- Deserializes host-issued 48-bit command frames and checks their framing and CRC7.
- Presents index and argument to a card-logic client, accepts a response through a valid/ready handshake, then serializes the R1/R3/R2 frame onto CMD after the required NCR gap.
- Runs on the system clock; a one-cycle strobe marks each SD clock rising edge.

Parameters:
- NCR_MIN, 2: minimum SD clocks between the command end bit and the response start bit.
- NCR_MAX, 64: SD clocks after the command end bit by which the response must be accepted; otherwise it is dropped.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_ck_stb  in  1  one i_clk pulse per SD clock rising edge; every CMD sample and every drive update occurs only on this strobe
- i_cmd  in  1  synchronized CMD line level
- o_cmd_oe  out  1  card drives CMD when high
- o_cmd  out  1  CMD drive value
- o_cmd_valid  out  1  one-cycle pulse: a valid command has been decoded
- o_cmd_idx  out  6  command index
- o_cmd_arg  out  32  command argument
- o_cmd_err  out  1  one-cycle pulse: bad transmission bit, bad end bit, or CRC7 mismatch
- i_rsp_valid  in  1  response offered
- o_rsp_ready  out  1  response can be accepted
- i_rsp_type  in  2  00 none, 01 R48 with CRC7 (R1/R6/R7), 10 R48 CRC field forced to 7'h7F (R3), 11 R136 (R2)
- i_rsp_data  in  120  R48: [37:32] index, [31:0] argument. R136: [119:0] CID/CSD[127:8]
- o_rsp_late  out  1  one-cycle pulse: response window expired

Behaviour:
- Reset, asynchronous: o_cmd_oe=0, o_cmd=1, o_cmd_valid=0, o_cmd_err=0, o_rsp_ready=0, o_rsp_late=0, idx=0, arg=0, state IDLE.
- A reset asserted mid-frame releases CMD immediately.
- IDLE: on i_ck_stb with i_cmd=0, record the start bit, clear the CRC, go to RX.
- RX: shift 47 further bits, MSB first.
  - CRC7 (poly x^7+x^3+1) runs over bits 47..8.
  - After the end bit, check: transmission bit=1, computed CRC == bits 7..1, end bit=1.
  - All pass: load idx/arg, pulse o_cmd_valid on the next i_clk, go to WAIT.
  - Any failure: pulse o_cmd_err, load nothing, return to IDLE.
- WAIT:
  - o_rsp_ready=1. A handshake (i_rsp_valid && o_rsp_ready) latches type and data.
  - The gap counter increments on each i_ck_stb starting after the end bit.
  - Type 00 accepted: go to IDLE, never drive.
  - Otherwise go to TX at the first i_ck_stb where the response is latched and gap >= NCR_MIN.
  - Gap reaches NCR_MAX with no handshake: pulse o_rsp_late, drop o_rsp_ready, go to IDLE.
  - A handshake and expiry in the same cycle: the handshake wins.
  - CMD input is ignored in WAIT and TX.
- TX:
  - o_cmd_oe=1 from the first i_ck_stb.
  - R48 bit stream: 0, 0, idx[5:0], arg[31:0], CRC7 (or 7'h7F for R3), 1.
  - R136 bit stream: 0, 0, 6'b111111, data[119:0], CRC7 over the 120 data bits only, 1.
  - One bit per i_ck_stb.
  - The end bit is held for one SD clock. On the following i_ck_stb, o_cmd_oe=0 and o_cmd=1, then the block returns to IDLE.
  - After release it honours a new start bit no earlier than the next i_ck_stb.
- i_ck_stb low: state, counters and o_cmd hold; handshake and pulse outputs still operate per i_clk.
- Bit counter: 8 bits, wide enough for 136.
- Gap counter: saturates at NCR_MAX.

Decomposition:
- Shared package sdcard_pkg:
  - state enum IDLE/RX/WAIT/TX
  - response-type constants RSP_NONE/RSP_R48/RSP_R3/RSP_R136
  - CRC7 polynomial 7'h09
  - frame lengths 48/136
- Sub-module sdcrc7: serial CRC7 with clear and bit-enable. One instance serves both RX checking and TX generation, since the two never overlap.

Test Plan:
- CMD0 frame 40 00 00 00 00 95 shifted in: o_cmd_valid pulses with idx=0, arg=0. Offer type 00: CMD never driven.
- CMD8 frame 48 00 00 01 AA 87: idx=8, arg=0x1AA. Respond R48 with {6'd8, 32'h1AA}: CMD stream is 08 00 00 01 AA followed by the golden-model CRC7 and end bit; start bit at exactly NCR_MIN clocks.
- CMD0 frame with the last byte corrupted to 0x97 (CRC bit flipped): o_cmd_err pulses, no o_cmd_valid, o_rsp_ready stays 0. The next good CMD0 decodes correctly.
- R3 response {6'h3F, 32'h00FF8000}: stream is 3F 00 FF 80 00 FF; o_cmd_oe falls one SD clock after the end bit.
- R2 response with data 120'h0123...: 136 bits, 6'b111111 header, CRC7 matching the golden model over the 120 data bits.
- Withhold i_rsp_valid: o_rsp_late pulses at gap=64. Also: assert i_reset_n=0 mid-TX, with o_cmd_oe=0 and o_cmd=1 required immediately.

Source files
------------

// File: rtl/sdcard_pkg.sv
// Shared definitions for the SD/eMMC CMD-line card endpoint.
//   state_t      : responder FSM states
//   RSP_*        : response type encodings carried on i_rsp_type
//   CRC7_POLY    : CRC7 polynomial x^7 + x^3 + 1 (implicit x^7 term)
//   *_LEN        : frame and CRC-covered payload lengths in bits
//   crc7_step    : advance a CRC7 register by one serial bit
package sdcard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    WAIT = 2'd2,
    TX   = 2'd3
  } state_t;

  localparam logic [1:0] RSP_NONE = 2'b00;
  localparam logic [1:0] RSP_R48  = 2'b01;
  localparam logic [1:0] RSP_R3   = 2'b10;
  localparam logic [1:0] RSP_R136 = 2'b11;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam logic [7:0] R48_LEN       = 8'd48;
  localparam logic [7:0] R136_LEN      = 8'd136;
  // Bits preceding the CRC field in each frame
  localparam logic [7:0] R48_BODY_LEN  = 8'd40;
  localparam logic [7:0] R136_BODY_LEN = 8'd128;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sdcrc7.sv
// Serial CRC7 generator/checker, MSB first.
//   i_clk     : system clock
//   i_reset_n : asynchronous active-low reset
//   i_clr     : restart from zero; combined with i_en the bit is folded into a fresh CRC
//   i_en      : fold i_bit into the running CRC
//   i_bit     : serial data bit
//   o_crc     : current CRC7 remainder
module sdcrc7
  import sdcard_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [6:0] o_crc
);

  logic [6:0] crc_reg;
  logic [6:0] crc_base;

  assign crc_base = i_clr ? 7'h00 : crc_reg;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      crc_reg <= 7'h00;
    end else if (i_en) begin
      crc_reg <= crc7_step(crc_base, i_bit);
    end else if (i_clr) begin
      crc_reg <= 7'h00;
    end
  end

  assign o_crc = crc_reg;

endmodule

// File: rtl/sdcard_cmd_responder.sv
// Card-side endpoint of the SD/eMMC CMD line.
// Receives 48-bit host commands, checks framing and CRC7, hands index and
// argument to card logic, then transmits the R1/R3/R2 response after the
// NCR gap. All line activity advances only on i_ck_stb.
//   i_clk, i_reset_n           : system clock, asynchronous active-low reset
//   i_ck_stb                   : one-cycle strobe per SD clock rising edge
//   i_cmd                      : synchronized CMD line level
//   o_cmd_oe, o_cmd            : CMD drive enable and value
//   o_cmd_valid, o_cmd_err     : decoded-command / bad-frame pulses
//   o_cmd_idx, o_cmd_arg       : last valid command index and argument
//   i_rsp_valid, o_rsp_ready   : response handshake
//   i_rsp_type, i_rsp_data     : response type and payload
//   o_rsp_late                 : pulse when the response window expires
module sdcard_cmd_responder
  import sdcard_pkg::*;
#(
  parameter int NCR_MIN = 2,
  parameter int NCR_MAX = 64
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_ck_stb,
  input  logic         i_cmd,
  output logic         o_cmd_oe,
  output logic         o_cmd,
  output logic         o_cmd_valid,
  output logic [5:0]   o_cmd_idx,
  output logic [31:0]  o_cmd_arg,
  output logic         o_cmd_err,
  input  logic         i_rsp_valid,
  output logic         o_rsp_ready,
  input  logic [1:0]   i_rsp_type,
  input  logic [119:0] i_rsp_data,
  output logic         o_rsp_late
);

  localparam int GW = $clog2(NCR_MAX + 1);
  localparam logic [GW-1:0] GAP_MIN = GW'(NCR_MIN);
  localparam logic [GW-1:0] GAP_MAX = GW'(NCR_MAX);

  state_t         state_reg, state_next;
  logic [7:0]     bit_cnt_reg, bit_cnt_next;
  logic [GW-1:0]  gap_reg, gap_next;
  logic [46:0]    rx_sr_reg, rx_sr_next;
  logic [127:0]   tx_sr_reg, tx_sr_next;
  logic [1:0]     rsp_type_reg, rsp_type_next;
  logic           rsp_latched_reg, rsp_latched_next;
  logic           cmd_oe_reg, cmd_oe_next;
  logic           cmd_reg, cmd_next;
  logic           cmd_valid_reg, cmd_valid_next;
  logic           cmd_err_reg, cmd_err_next;
  logic           rsp_late_reg, rsp_late_next;
  logic [5:0]     cmd_idx_reg, cmd_idx_next;
  logic [31:0]    cmd_arg_reg, cmd_arg_next;

  logic           crc_clr, crc_en, crc_bit;
  logic [6:0]     crc_out, crc_val;
  logic [47:0]    rx_frame;
  logic           rx_ok, hs;
  logic [7:0]     tx_body_len, tx_frame_len;

  sdcrc7 u_crc (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clr     (crc_clr),
    .i_en      (crc_en),
    .i_bit     (crc_bit),
    .o_crc     (crc_out)
  );

  // Only valid on the strobe that samples the end bit (bit_cnt_reg == 47)
  assign rx_frame = {rx_sr_reg, i_cmd};
  assign rx_ok    = !rx_frame[47] && rx_frame[46] &&
                    (crc_out == rx_frame[7:1]) && rx_frame[0];

  assign o_rsp_ready  = (state_reg == WAIT) && !rsp_latched_reg;
  assign hs           = i_rsp_valid && o_rsp_ready;
  assign tx_body_len  = (rsp_type_reg == RSP_R136) ? R136_BODY_LEN : R48_BODY_LEN;
  assign tx_frame_len = (rsp_type_reg == RSP_R136) ? R136_LEN : R48_LEN;
  assign crc_val      = (rsp_type_reg == RSP_R3) ? 7'h7F : crc_out;

  always_comb begin
    state_next       = state_reg;
    bit_cnt_next     = bit_cnt_reg;
    gap_next         = gap_reg;
    rx_sr_next       = rx_sr_reg;
    tx_sr_next       = tx_sr_reg;
    rsp_type_next    = rsp_type_reg;
    rsp_latched_next = rsp_latched_reg;
    cmd_oe_next      = cmd_oe_reg;
    cmd_next         = cmd_reg;
    cmd_valid_next   = 1'b0;
    cmd_err_next     = 1'b0;
    rsp_late_next    = 1'b0;
    cmd_idx_next     = cmd_idx_reg;
    cmd_arg_next     = cmd_arg_reg;
    crc_clr          = 1'b0;
    crc_en           = 1'b0;
    crc_bit          = i_cmd;

    case (state_reg)
      IDLE: begin
        if (i_ck_stb && !i_cmd) begin
          // Start bit is folded into a freshly cleared CRC
          state_next   = RX;
          bit_cnt_next = 8'd1;
          rx_sr_next   = '0;
          crc_clr      = 1'b1;
          crc_en       = 1'b1;
        end
      end

      RX: begin
        if (i_ck_stb) begin
          rx_sr_next   = {rx_sr_reg[45:0], i_cmd};
          bit_cnt_next = bit_cnt_reg + 8'd1;
          crc_en       = (bit_cnt_reg < R48_BODY_LEN);
          if (bit_cnt_reg == R48_LEN - 8'd1) begin
            if (rx_ok) begin
              state_next       = WAIT;
              cmd_valid_next   = 1'b1;
              cmd_idx_next     = rx_frame[45:40];
              cmd_arg_next     = rx_frame[39:8];
              gap_next         = '0;
              rsp_latched_next = 1'b0;
            end else begin
              state_next   = IDLE;
              cmd_err_next = 1'b1;
            end
          end
        end
      end

      WAIT: begin
        if (i_ck_stb && (gap_reg < GAP_MAX)) begin
          gap_next = gap_reg + 1'b1;
        end
        if (hs) begin
          // Handshake takes priority over an expiry in the same cycle
          rsp_type_next    = i_rsp_type;
          rsp_latched_next = 1'b1;
          tx_sr_next       = (i_rsp_type == RSP_R136) ?
                             {2'b00, 6'h3F, i_rsp_data} :
                             {2'b00, i_rsp_data[37:0], 88'd0};
          if (i_rsp_type == RSP_NONE) begin
            state_next       = IDLE;
            rsp_latched_next = 1'b0;
          end
        end else if (!rsp_latched_reg && (gap_reg >= GAP_MAX)) begin
          state_next    = IDLE;
          rsp_late_next = 1'b1;
        end else if (i_ck_stb && rsp_latched_reg && (gap_reg >= GAP_MIN)) begin
          // This strobe drives the start bit; frame bit 0 is outside the
          // R136 CRC coverage, so only R48 folds it in
          state_next   = TX;
          cmd_oe_next  = 1'b1;
          cmd_next     = tx_sr_reg[127];
          tx_sr_next   = {tx_sr_reg[126:0], 1'b0};
          bit_cnt_next = 8'd1;
          crc_clr      = 1'b1;
          crc_en       = (rsp_type_reg != RSP_R136);
          crc_bit      = tx_sr_reg[127];
        end
      end

      TX: begin
        if (i_ck_stb) begin
          if (bit_cnt_reg == tx_frame_len) begin
            // End bit has been held for one SD clock; release the line
            state_next  = IDLE;
            cmd_oe_next = 1'b0;
            cmd_next    = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt_reg + 8'd1;
            if (bit_cnt_reg == tx_body_len) begin
              // Drop the finished CRC plus the end bit into the top of the
              // shifter so the remaining bits stream out unchanged
              cmd_next   = crc_val[6];
              tx_sr_next = {crc_val[5:0], 1'b1, tx_sr_reg[120:0]};
            end else begin
              cmd_next   = tx_sr_reg[127];
              tx_sr_next = {tx_sr_reg[126:0], 1'b0};
              crc_bit    = tx_sr_reg[127];
              crc_en     = (bit_cnt_reg < tx_body_len) &&
                           ((rsp_type_reg != RSP_R136) || (bit_cnt_reg >= 8'd8));
            end
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg       <= IDLE;
      bit_cnt_reg     <= 8'd0;
      gap_reg         <= '0;
      rx_sr_reg       <= '0;
      tx_sr_reg       <= '0;
      rsp_type_reg    <= RSP_NONE;
      rsp_latched_reg <= 1'b0;
      cmd_oe_reg      <= 1'b0;
      cmd_reg         <= 1'b1;
      cmd_valid_reg   <= 1'b0;
      cmd_err_reg     <= 1'b0;
      rsp_late_reg    <= 1'b0;
      cmd_idx_reg     <= 6'd0;
      cmd_arg_reg     <= 32'd0;
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      gap_reg         <= gap_next;
      rx_sr_reg       <= rx_sr_next;
      tx_sr_reg       <= tx_sr_next;
      rsp_type_reg    <= rsp_type_next;
      rsp_latched_reg <= rsp_latched_next;
      cmd_oe_reg      <= cmd_oe_next;
      cmd_reg         <= cmd_next;
      cmd_valid_reg   <= cmd_valid_next;
      cmd_err_reg     <= cmd_err_next;
      rsp_late_reg    <= rsp_late_next;
      cmd_idx_reg     <= cmd_idx_next;
      cmd_arg_reg     <= cmd_arg_next;
    end
  end

  assign o_cmd_oe    = cmd_oe_reg;
  assign o_cmd       = cmd_reg;
  assign o_cmd_valid = cmd_valid_reg;
  assign o_cmd_err   = cmd_err_reg;
  assign o_rsp_late  = rsp_late_reg;
  assign o_cmd_idx   = cmd_idx_reg;
  assign o_cmd_arg   = cmd_arg_reg;

endmodule
